// File: rtl/dsram_master_pkg.sv
// dsram_master_pkg: shared definitions for the data-SRAM initiator.
//   Access sizes, response error codes, FSM state encoding and small
//   helpers for the size byte-mask and the natural-alignment test.
package dsram_master_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_RANGE    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Unshifted byte-enable pattern for an access of the given size.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_B:  return 8'h01;
            SIZE_H:  return 8'h03;
            SIZE_W:  return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Natural alignment: the low log2(size) address bits must be zero.
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lo);
        case (size)
            SIZE_H:  return lo[0];
            SIZE_W:  return |lo[1:0];
            SIZE_D:  return |lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dsram_master_lane_fmt.sv
// dsram_master_lane_fmt: combinational lane formatter.
//   Store side: replicates the LSB-justified store data across all lanes and
//   produces the byte enables for the addressed lanes.
//   Load side: shifts the addressed lane down to bit 0, masks to the access
//   size and sign/zero-extends.
// Ports:
//   size        in  2   access size (B/H/W/D)
//   byte_off    in  3   byte offset within the 64-bit word
//   is_unsigned in  1   zero-extend loads (ignored for D)
//   wdata       in  64  store data, LSB-justified
//   rdata       in  64  raw SRAM read word
//   wdata_lanes out 64  replicated store data
//   byte_en     out 8   byte enables for the addressed lanes
//   load_data   out 64  extracted and extended load result
module dsram_master_lane_fmt
    import dsram_master_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [2:0]  byte_off,
    input  logic        is_unsigned,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata,
    output logic [63:0] wdata_lanes,
    output logic [7:0]  byte_en,
    output logic [63:0] load_data
);

    logic [63:0] shifted;
    logic        sign_ext;

    always_comb begin
        shifted  = rdata >> {byte_off, 3'b000};
        sign_ext = ~is_unsigned;
        byte_en  = size_mask(size) << byte_off;
        case (size)
            SIZE_B: begin
                wdata_lanes = {8{wdata[7:0]}};
                load_data   = {{56{sign_ext & shifted[7]}}, shifted[7:0]};
            end
            SIZE_H: begin
                wdata_lanes = {4{wdata[15:0]}};
                load_data   = {{48{sign_ext & shifted[15]}}, shifted[15:0]};
            end
            SIZE_W: begin
                wdata_lanes = {2{wdata[31:0]}};
                load_data   = {{32{sign_ext & shifted[31]}}, shifted[31:0]};
            end
            default: begin
                wdata_lanes = wdata;
                load_data   = shifted;
            end
        endcase
    end

endmodule

// File: rtl/dsram_master.sv
// dsram_master: initiator for the 64-bit byte-enable data SRAM.
//   Turns sized load/store requests from the LSU into single SRAM cycles,
//   checks alignment and window range, and returns one response per request
//   with a single transaction outstanding.
// Ports:
//   clk, resetn                     clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_we, req_size, req_unsigned  store flag, size (B/H/W/D), load zero-extend
//   req_addr, req_wdata             byte address, LSB-justified store data
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata, rsp_err              load result, error code (ok/misalign/range)
//   sram_en, sram_we                SRAM enable and byte write enables
//   sram_addr, sram_wdata           SRAM word address and lane-aligned data
//   sram_rdata                      SRAM read data (cycle after the read)
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | ready for a request; SRAM driven combinationally on accept
// ST_RD   | SRAM read data arriving; extract lane into rsp_rdata
// ST_RESP | response held stable until rsp_ready
module dsram_master
    import dsram_master_pkg::*;
#(
    parameter int          SRAM_AW   = 14,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [1:0]         req_size,
    input  logic               req_unsigned,
    input  logic [63:0]        req_addr,
    input  logic [63:0]        req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [63:0]        rsp_rdata,
    output logic [1:0]         rsp_err,
    output logic               sram_en,
    output logic [7:0]         sram_we,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [63:0]        sram_wdata,
    input  logic [63:0]        sram_rdata
);

    localparam logic [63:0] WIN_BYTES = 64'd1 << (SRAM_AW + 3);

    state_t             state;
    logic               ready_q;
    logic [1:0]         size_q;
    logic               unsigned_q;
    logic [2:0]         off_q;
    logic [SRAM_AW-1:0] addr_q;
    logic [63:0]        wdata_q;

    logic [63:0] offset;
    logic [1:0]  req_err;
    logic        accept;
    logic        access;
    logic [1:0]  fmt_size;
    logic [2:0]  fmt_off;
    logic        fmt_unsigned;
    logic [63:0] wdata_lanes;
    logic [7:0]  byte_en;
    logic [63:0] load_data;

    // Modular subtraction: an address below the base wraps to a huge offset,
    // so a single unsigned compare covers both ends of the window.
    assign offset = req_addr - BASE_ADDR;

    always_comb begin
        if (misaligned(req_size, req_addr[2:0])) begin
            req_err = ERR_MISALIGN;
        end else if (offset >= WIN_BYTES) begin
            req_err = ERR_RANGE;
        end else begin
            req_err = ERR_OK;
        end
    end

    // ready_q is only high in ST_IDLE, so it alone qualifies the accept.
    assign accept    = req_valid & ready_q;
    assign access    = accept & (req_err == ERR_OK);
    assign req_ready = ready_q;

    // The formatter is shared: in ST_RD it works on the captured load
    // attributes, otherwise on the live request.
    always_comb begin
        if (state == ST_RD) begin
            fmt_size     = size_q;
            fmt_off      = off_q;
            fmt_unsigned = unsigned_q;
        end else begin
            fmt_size     = req_size;
            fmt_off      = req_addr[2:0];
            fmt_unsigned = req_unsigned;
        end
    end

    dsram_master_lane_fmt u_lane_fmt (
        .size        (fmt_size),
        .byte_off    (fmt_off),
        .is_unsigned (fmt_unsigned),
        .wdata       (req_wdata),
        .rdata       (sram_rdata),
        .wdata_lanes (wdata_lanes),
        .byte_en     (byte_en),
        .load_data   (load_data)
    );

    assign sram_en    = access;
    assign sram_we    = (access & req_we) ? byte_en : 8'h00;
    assign sram_addr  = access ? offset[SRAM_AW+2:3] : addr_q;
    assign sram_wdata = access ? wdata_lanes : wdata_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            ready_q    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 64'd0;
            rsp_err    <= ERR_OK;
            size_q     <= SIZE_B;
            unsigned_q <= 1'b0;
            off_q      <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= 64'd0;
        end else begin
            if (access) begin
                addr_q  <= offset[SRAM_AW+2:3];
                wdata_q <= wdata_lanes;
            end
            case (state)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        ready_q <= 1'b0;
                        if (req_err != ERR_OK || req_we) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= 64'd0;
                            rsp_err   <= req_err;
                        end else begin
                            state      <= ST_RD;
                            size_q     <= req_size;
                            unsigned_q <= req_unsigned;
                            off_q      <= req_addr[2:0];
                        end
                    end
                end
                ST_RD: begin
                    state     <= ST_RESP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= load_data;
                    rsp_err   <= ERR_OK;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        ready_q   <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 64'd0;
                        rsp_err   <= ERR_OK;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsram_master.sv
// tb_dsram_master: scoreboard bench for dsram_master with a byte-level
// reference memory and a word-level SRAM model driven by the DUT's own
// byte enables.
module tb_dsram_master;

    localparam int          AW   = 14;
    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam logic [63:0] WIN  = 64'h0002_0000;

    logic          clk;
    logic          resetn;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [63:0]   req_addr;
    logic [63:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [63:0]   rsp_rdata;
    logic [1:0]    rsp_err;
    logic          sram_en;
    logic [7:0]    sram_we;
    logic [AW-1:0] sram_addr;
    logic [63:0]   sram_wdata;
    logic [63:0]   sram_rdata;

    dsram_master #(.SRAM_AW(AW), .BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .sram_en      (sram_en),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Initial SRAM contents, shared by the SRAM model and the reference model.
    function automatic logic [63:0] init_word(input int idx);
        if (idx == 0) return 64'h8000_0001_0000_0000;
        return {32'(idx) * 32'h9E37_79B9, ~(32'(idx) * 32'h85EB_CA6B)};
    endfunction

    // ---------------- SRAM model ----------------
    logic [63:0] smem     [0:16383];
    bit          swritten [0:16383];

    function automatic logic [63:0] sram_cur(input logic [AW-1:0] a);
        return swritten[a] ? smem[a] : init_word(int'(a));
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw, input logic [7:0] be);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    initial sram_rdata = 64'd0;

    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we == 8'h00) begin
                sram_rdata <= sram_cur(sram_addr);
            end else begin
                smem[sram_addr]     <= merge(sram_cur(sram_addr), sram_wdata, sram_we);
                swritten[sram_addr] <= 1'b1;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] refmem [longint];

    function automatic logic [7:0] ref_byte(input longint off);
        logic [63:0] w;
        if (refmem.exists(off)) return refmem[off];
        w = init_word(int'(off / 8));
        return w[8 * int'(off % 8) +: 8];
    endfunction

    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         output logic [1:0] err, output logic [63:0] rdata);
        int          n;
        longint      off;
        logic [63:0] v;
        n     = 1 << size;
        rdata = 64'd0;
        if ((addr % 64'(n)) != 64'd0) begin
            err = 2'd1;
        end else if (addr < BASE || addr >= BASE + WIN) begin
            err = 2'd2;
        end else begin
            err = 2'd0;
            off = longint'(addr - BASE);
            if (we) begin
                for (int i = 0; i < n; i++) refmem[off + i] = wdata[8*i +: 8];
            end else begin
                v = 64'd0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = ref_byte(off + i);
                if (!uns && n < 8 && v[8*n-1])
                    for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
                rdata = v;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [1:0]  err;
        logic [63:0] rdata;
        longint      acc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   stall_left = 0;

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata);
        int          guard;
        int          n;
        int          lo;
        logic [1:0]  e;
        logic [63:0] r;
        logic [7:0]  m;
        logic [63:0] rep;
        exp_t        x;
        guard = 0;
        while (!req_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check64("req_ready_timeout", {63'd0, req_ready}, 64'd1);
            return;
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        model(we, size, uns, addr, wdata, e, r);
        #1;
        n  = 1 << size;
        lo = int'(addr[2:0]);
        m  = 8'h00;
        for (int i = 0; i < 8; i++) if (i >= lo && i < lo + n) m[i] = 1'b1;
        for (int i = 0; i < 8; i++) rep[8*i +: 8] = wdata[8*(i % n) +: 8];
        check64("accept_sram_en", {63'd0, sram_en}, {63'd0, e == 2'd0});
        check64("accept_sram_we", {56'd0, sram_we}, (e == 2'd0 && we) ? {56'd0, m} : 64'd0);
        if (e == 2'd0) check64("accept_sram_addr", {50'd0, sram_addr}, (addr - BASE) >> 3);
        if (e == 2'd0 && we) check64("accept_sram_wdata", sram_wdata, rep);
        x.err   = e;
        x.rdata = r;
        x.acc   = cyc;
        x.lat   = (e == 2'd0 && !we) ? 2 : 1;
        exp_q.push_back(x);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check64("idle_sram_en", {63'd0, sram_en}, 64'd0);
        check64("idle_sram_we", {56'd0, sram_we}, 64'd0);
    endtask

    // Monitor: latency, payload, stability under back-pressure.
    bit          seen;
    bit          hold;
    logic [63:0] hold_rdata;
    logic [1:0]  hold_err;

    initial begin
        exp_t x;
        rsp_ready = 1'b0;
        seen      = 1'b0;
        hold      = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                seen = 1'b0;
                hold = 1'b0;
                continue;
            end
            if (hold) begin
                check64("hold_rsp_valid", {63'd0, rsp_valid}, 64'd1);
                check64("hold_rsp_rdata", rsp_rdata, hold_rdata);
                check64("hold_rsp_err", {62'd0, rsp_err}, {62'd0, hold_err});
            end
            if (stall_left > 0) begin
                rsp_ready = 1'b0;
                if (rsp_valid) stall_left--;
            end else begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
            if (rsp_valid) check64("busy_req_ready", {63'd0, req_ready}, 64'd0);
            if (rsp_valid && !seen) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp actual=rsp_valid required=no_response");
                end else begin
                    check64("rsp_latency", 64'(cyc - exp_q[0].acc), 64'(exp_q[0].lat));
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() != 0) begin
                    x = exp_q.pop_front();
                    check64("rsp_err", {62'd0, rsp_err}, {62'd0, x.err});
                    check64("rsp_rdata", rsp_rdata, x.rdata);
                end
                seen = 1'b0;
            end
            hold       = rsp_valid && !rsp_ready;
            hold_rdata = rsp_rdata;
            hold_err   = rsp_err;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0]  sz;
        logic [63:0] addr;
        int          r;
        int          guard;
        resetn       = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 64'd0;
        req_wdata    = 64'd0;
        repeat (3) @(negedge clk);
        check64("rst_req_ready", {63'd0, req_ready}, 64'd0);
        check64("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check64("rst_rsp_rdata", rsp_rdata, 64'd0);
        check64("rst_rsp_err", {62'd0, rsp_err}, 64'd0);
        check64("rst_sram_en", {63'd0, sram_en}, 64'd0);
        check64("rst_sram_we", {56'd0, sram_we}, 64'd0);
        check64("rst_sram_addr", {50'd0, sram_addr}, 64'd0);
        check64("rst_sram_wdata", sram_wdata, 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check64("post_rst_req_ready", {63'd0, req_ready}, 64'd1);

        // Directed cases around word 0 = 0x80000001_00000000.
        stall_left = 5;
        issue(1'b0, 2'd2, 1'b0, BASE + 64'd4, 64'd0);
        issue(1'b0, 2'd1, 1'b1, BASE + 64'd6, 64'd0);
        issue(1'b1, 2'd0, 1'b0, BASE + 64'd5, 64'hAB);
        issue(1'b0, 2'd3, 1'b0, BASE + 64'd4, 64'd0);
        issue(1'b1, 2'd3, 1'b0, BASE + WIN, 64'h1234_5678_9ABC_DEF0);
        issue(1'b0, 2'd3, 1'b0, BASE + WIN - 64'd8, 64'd0);
        issue(1'b1, 2'd2, 1'b0, BASE + WIN - 64'd4, 64'hDEAD_BEEF);
        issue(1'b0, 2'd2, 1'b0, BASE + WIN - 64'd4, 64'd0);
        issue(1'b0, 2'd0, 1'b1, BASE - 64'd1, 64'd0);
        issue(1'b0, 2'd0, 1'b0, BASE + 64'd5, 64'd0);

        // Reset while the load sits in its read cycle.
        issue(1'b0, 2'd3, 1'b0, BASE, 64'd0);
        resetn = 1'b0;
        exp_q.delete();
        #1;
        check64("midrd_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check64("midrd_rst_req_ready", {63'd0, req_ready}, 64'd0);
        check64("midrd_rst_rsp_rdata", rsp_rdata, 64'd0);
        check64("midrd_rst_sram_addr", {50'd0, sram_addr}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check64("post_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        end
        issue(1'b0, 2'd3, 1'b0, BASE + 64'd8, 64'd0);

        // Randomised traffic.
        for (int k = 0; k < 200; k++) begin
            r  = $urandom_range(0, 99);
            sz = 2'($urandom_range(0, 3));
            if (r < 80) begin
                addr = 64'($urandom_range(0, 255));
                if ($urandom_range(0, 4) != 0) addr = addr & ~((64'd1 << sz) - 64'd1);
                addr = BASE + addr;
            end else if (r < 88) begin
                addr = BASE + WIN - 64'd8 + 64'($urandom_range(0, 7));
            end else if (r < 94) begin
                addr = BASE + WIN + 64'(8 * $urandom_range(0, 8));
            end else begin
                addr = BASE - 64'(8 * $urandom_range(1, 4));
            end
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr,
                  {$urandom, $urandom});
        end

        guard = 0;
        while ((exp_q.size() != 0 || rsp_valid) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check64("drain_pending", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
